// File: rtl/key_pkg.sv
// key_pkg: shared types and sizing helpers for the key conditioner.
// Configuration macro: KEY_AUTOREPEAT_EN (consumed by key_debounce).
package key_pkg;

    localparam int unsigned NUM_KEYS = 4;

    // Per-key debounce FSM states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressDb = 2'd1,
        StHeld    = 2'd2,
        StRelDb   = 2'd3
    } key_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val inclusive, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser, debounce FSM and counters for a single active-low key.
// Configuration macro: KEY_AUTOREPEAT_EN adds the auto-repeat timer in the held state.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS     = 20,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic key_raw,
    output logic key_clean,
    output logic key_press,
    output logic key_held
);

    localparam int unsigned CNT_W =
        cnt_width(max_u(DEBOUNCE_TICKS, max_u(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS)));
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             press_q, press_d;
    logic             rep_fire;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // State register, debounce counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
        end
    end

    // Next state: the FSM only advances on tick cycles; the counter saturates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!sync2_q) begin
                        state_d = StPressDb;
                        cnt_d   = CNT_ONE;
                    end
                end
                StPressDb: begin
                    if (sync2_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LIMIT) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    if (sync2_q) begin
                        state_d = StRelDb;
                        cnt_d   = CNT_ONE;
                    end
                end
                StRelDb: begin
                    if (!sync2_q) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LIMIT) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs: clean level and press pulse change on the accepting transition.
    always_comb begin
        clean_d = clean_q;
        press_d = rep_fire;
        if (state_q == StPressDb && state_d == StHeld) begin
            clean_d = 1'b0;
            press_d = 1'b1;
        end
        if (state_q == StRelDb && state_d == StIdle) begin
            clean_d = 1'b1;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LIMIT = CNT_W'(REPEAT_DELAY_TICKS);
    localparam logic [CNT_W-1:0] RATE_LIMIT  = CNT_W'(REPEAT_RATE_TICKS);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
    logic             rep_run_q, rep_run_d;      // armed for the current acceptance
    logic             rep_first_q, rep_first_d;  // initial delay already elapsed

    // Repeat timer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_run_q   <= 1'b0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_run_q   <= rep_run_d;
            rep_first_q <= rep_first_d;
        end
    end

    // Armed on acceptance, counts ticks spent in HELD, disarmed once a release starts.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_run_d   = rep_run_q;
        rep_first_d = rep_first_q;
        rep_next    = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + 1'b1;
        rep_fire    = 1'b0;
        if (state_q == StPressDb && state_d == StHeld) begin
            rep_cnt_d   = '0;
            rep_run_d   = 1'b1;
            rep_first_d = 1'b0;
        end else if (state_q == StHeld && state_d == StRelDb) begin
            rep_cnt_d   = '0;
            rep_run_d   = 1'b0;
            rep_first_d = 1'b0;
        end else if (tick && rep_run_q && state_q == StHeld && state_d == StHeld) begin
            if (rep_next == (rep_first_q ? RATE_LIMIT : DELAY_LIMIT)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_next;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign key_clean = clean_q;
    assign key_press = press_q;
    assign key_held  = (state_q == StHeld) || (state_q == StRelDb);

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces the four active-low KEY inputs and generates the button clock.
// Configuration macro: KEY_AUTOREPEAT_EN enables auto-repeat press pulses while a key is held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned TICK_DIV           = 50000,
    parameter int unsigned DEBOUNCE_TICKS     = 20,
    parameter int unsigned BTNCLK_HALF_TICKS  = 5,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyRaw,
    output logic [NUM_KEYS-1:0] keyClean,
    output logic [NUM_KEYS-1:0] keyPress,
    output logic [NUM_KEYS-1:0] keyHeld,
    output logic                buttonClockOut
);

    localparam int unsigned      TICK_W    = cnt_width(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int unsigned      BTN_W     = cnt_width(BTNCLK_HALF_TICKS - 1);
    localparam logic [BTN_W-1:0]  BTN_LAST  = BTN_W'(BTNCLK_HALF_TICKS - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic [BTN_W-1:0]  btn_cnt_q;
    logic              btn_clk_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Free-running divider: one tick per TICK_DIV system clocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Button clock toggles every BTNCLK_HALF_TICKS ticks, giving an exact 50% duty cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_cnt_q <= '0;
            btn_clk_q <= 1'b0;
        end else if (tick) begin
            if (btn_cnt_q == BTN_LAST) begin
                btn_cnt_q <= '0;
                btn_clk_q <= ~btn_clk_q;
            end else begin
                btn_cnt_q <= btn_cnt_q + 1'b1;
            end
        end
    end

    assign buttonClockOut = btn_clk_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
        ) u_key_debounce (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .key_raw  (keyRaw[k]),
            .key_clean(keyClean[k]),
            .key_press(keyPress[k]),
            .key_held (keyHeld[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: randomized bench with a run-length reference model and a press scoreboard.
module tb_key_conditioner;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned DEB      = 4;
    localparam int unsigned HALF     = 2;
    localparam int unsigned RDELAY   = 20;
    localparam int unsigned RRATE    = 5;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keyRaw = 4'hF;
    logic [3:0] keyClean, keyPress, keyHeld;
    logic       buttonClockOut;

    always #5 clock = ~clock;

    key_conditioner #(
        .TICK_DIV          (TICK_DIV),
        .DEBOUNCE_TICKS    (DEB),
        .BTNCLK_HALF_TICKS (HALF),
        .REPEAT_DELAY_TICKS(RDELAY),
        .REPEAT_RATE_TICKS (RRATE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .keyRaw        (keyRaw),
        .keyClean      (keyClean),
        .keyPress      (keyPress),
        .keyHeld       (keyHeld),
        .buttonClockOut(buttonClockOut)
    );

    typedef struct {
        int unsigned stamp;
        logic [3:0]  mask;
    } press_t;

    press_t      exp_q[$];
    int unsigned cyc      = 0;
    int          total    = 0;
    int          bad      = 0;
    int unsigned pulses0  = 0;
    bit          checking = 1'b0;

    // Reference model: raw delayed two clocks, sampled once per tick; a key flips its
    // accepted level after DEB+1 consecutive samples that disagree with it.
    logic [3:0]  m_s1, m_s2, m_level;
    int unsigned m_run[4];
    int unsigned m_rep_ticks[4];
    bit          m_rep_on[4];
    int unsigned m_tdiv, m_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) begin
        logic [3:0] fire;
        cyc++;
        fire = 4'h0;
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_level = 4'hF;
            m_tdiv = 0; m_ticks = 0;
            for (int k = 0; k < 4; k++) begin
                m_run[k] = 0; m_rep_ticks[k] = 0; m_rep_on[k] = 1'b0;
            end
            exp_q.delete();
        end else begin
            if (m_tdiv == TICK_DIV - 1) begin
                m_tdiv = 0;
                m_ticks++;
                for (int k = 0; k < 4; k++) begin
                    if (m_s2[k] != m_level[k]) begin
                        m_run[k]++;
                        if (!m_level[k]) m_rep_on[k] = 1'b0;
                        if (m_run[k] == DEB + 1) begin
                            m_level[k] = m_s2[k];
                            m_run[k]   = 0;
                            if (!m_level[k]) begin
                                fire[k] = 1'b1;
                                m_rep_on[k] = 1'b1;
                                m_rep_ticks[k] = 0;
                            end
                        end
                    end else begin
                        m_run[k] = 0;
                        if (!m_level[k] && m_rep_on[k]) begin
                            m_rep_ticks[k]++;
                            if (AUTOREP && (m_rep_ticks[k] == RDELAY ||
                                (m_rep_ticks[k] > RDELAY && (m_rep_ticks[k] - RDELAY) % RRATE == 0)))
                                fire[k] = 1'b1;
                        end
                    end
                end
            end else begin
                m_tdiv++;
            end
            m_s2 = m_s1;
            m_s1 = keyRaw;
        end
        if (fire != 4'h0) exp_q.push_back('{stamp: cyc, mask: fire});
    end

    // Monitor: levels every cycle, press pulses against the scoreboard.
    always @(negedge clock) begin
        if (checking) begin
            check("keyClean", {28'h0, keyClean}, {28'h0, m_level});
            check("keyHeld", {28'h0, keyHeld}, {28'h0, ~m_level});
            check("buttonClockOut", {31'h0, buttonClockOut}, ((m_ticks / HALF) % 2));
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                total++; bad++;
                $display("FAIL missed_press cyc=%0d got=none want=%0h@%0d", cyc, exp_q[0].mask,
                         exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
            if (keyPress != 4'h0) begin
                if (keyPress[0]) pulses0++;
                if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                    check("keyPress", {28'h0, keyPress}, {28'h0, exp_q[0].mask});
                    void'(exp_q.pop_front());
                end else begin
                    total++; bad++;
                    $display("FAIL unexpected_press cyc=%0d got=%0h want=0", cyc, keyPress);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int unsigned t0, lat, p0;
        bit found;
        reset = 1'b1;
        keyRaw = 4'hF;
        cycles(3);
        checking = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(45);

        // Key 0 press latency must land in the 40..52 clock window.
        t0 = cyc; found = 1'b0; lat = 0;
        keyRaw[0] = 1'b0;
        for (int i = 0; i < 70 && !found; i++) begin
            @(negedge clock);
            if (keyPress[0]) begin found = 1'b1; lat = cyc - t0; end
        end
        total++;
        if (!found || lat < 40 || lat > 52) begin
            bad++;
            $display("FAIL press_latency got=%0d found=%0d want=40..52", lat, found);
        end
        cycles(10);
        keyRaw[0] = 1'b1;
        cycles(80);

        // Key 1 with a one-tick release glitch.
        keyRaw[1] = 1'b0; cycles(15);
        keyRaw[1] = 1'b1; cycles(10);
        keyRaw[1] = 1'b0; cycles(80);
        keyRaw[1] = 1'b1; cycles(80);

        // Keys 2 and 3 together.
        keyRaw[3:2] = 2'b00; cycles(80);
        keyRaw[3:2] = 2'b11; cycles(80);

        // Reset while key 0 is mid-debounce, key kept low through release.
        keyRaw[0] = 1'b0; cycles(25);
        reset = 1'b1; cycles(3);
        reset = 1'b0; cycles(80);
        keyRaw[0] = 1'b1; cycles(80);

        // Long hold: auto-repeat count depends on the build.
        p0 = pulses0;
        keyRaw[0] = 1'b0; cycles(400);
        keyRaw[0] = 1'b1; cycles(80);
        total++;
        if ((pulses0 - p0) != (AUTOREP ? 5 : 1)) begin
            bad++;
            $display("FAIL hold_pulses got=%0d want=%0d", pulses0 - p0, AUTOREP ? 5 : 1);
        end

        // Random phase: level changes, short glitches, occasional reset.
        for (int s = 0; s < 40; s++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset = 1'b1; cycles(2); reset = 1'b0;
            end else if (r < 6) begin
                logic [3:0] g;
                g = 4'($urandom);
                keyRaw = keyRaw ^ g;
                cycles($urandom_range(1, 15));
                keyRaw = keyRaw ^ g;
            end else begin
                keyRaw = 4'($urandom);
            end
            cycles($urandom_range(20, 120));
        end

        keyRaw = 4'hF;
        cycles(100);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
